// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared KNN constants, vote FSM states and width helper
// Shared by the sorter and the vote stage so both agree on N, W, K and C.
package knn_pkg;

  localparam int KNN_N = 8;
  localparam int KNN_W = 16;
  localparam int KNN_K = 5;
  localparam int KNN_C = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } vote_state_e;

  // Width needed to hold a vote count in 0..k (also a position in 0..k).
  function automatic int calc_cw(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_vote_tally.sv
// rtl/knn_vote_tally.sv - per-class vote count and first-position register file
// Ports: clk/rst (sync, active-high); clr zeroes every entry;
//   inc_en/inc_label/inc_idx bump cnt[label] and record idx as first_pos on the first hit;
//   rd_cls selects the entry shown on rd_cnt/rd_first_pos.
module knn_vote_tally
  import knn_pkg::*;
#(
  parameter int K = KNN_K,
  parameter int C = KNN_C,
  localparam int CW = calc_cw(K),
  localparam int LW = $clog2(C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_en,
  input  logic [LW-1:0] inc_label,
  input  logic [CW-1:0] inc_idx,
  input  logic [LW-1:0] rd_cls,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] rd_first_pos
);

  logic [CW-1:0] cnt_q       [C];
  logic [CW-1:0] cnt_d       [C];
  logic [CW-1:0] first_pos_q [C];
  logic [CW-1:0] first_pos_d [C];

  // A tally can never exceed K, which fits in CW bits, so no saturation.
  always_comb begin
    for (int c = 0; c < C; c++) begin
      cnt_d[c]       = cnt_q[c];
      first_pos_d[c] = first_pos_q[c];
      if (clr) begin
        cnt_d[c]       = '0;
        first_pos_d[c] = '0;
      end else if (inc_en && (inc_label == LW'(c))) begin
        if (cnt_q[c] == '0) begin
          first_pos_d[c] = inc_idx;
        end
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end
  end

  always_comb begin
    rd_cnt       = '0;
    rd_first_pos = '0;
    for (int c = 0; c < C; c++) begin
      if (rd_cls == LW'(c)) begin
        rd_cnt       = cnt_q[c];
        rd_first_pos = first_pos_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        cnt_q[c]       <= '0;
        first_pos_q[c] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      first_pos_q <= first_pos_d;
    end
  end

endmodule

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - majority-vote classifier over the K nearest sorted neighbours
// Ports: clk/rst (sync, active-high); valid_sort pulse with distance_array_sorted/type_array_sorted;
//   class_out/votes_out/nearest_dist/type_err held between results, class_valid one-cycle pulse;
//   busy (not IDLE); overrun sticky flag for valid_sort arriving while busy.
module knn_vote
  import knn_pkg::*;
#(
  parameter int N = KNN_N,
  parameter int W = KNN_W,
  parameter int K = KNN_K,
  parameter int C = KNN_C,
  localparam int CW = calc_cw(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_sort,
  input  logic [W-1:0]  distance_array_sorted [0:N-1],
  input  logic [W-1:0]  type_array_sorted     [0:N-1],
  output logic [W-1:0]  class_out,
  output logic [CW-1:0] votes_out,
  output logic [W-1:0]  nearest_dist,
  output logic          type_err,
  output logic          class_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int LW = $clog2(C);

  vote_state_e   state_q, state_d;
  logic [W-1:0]  dist_q [0:K-1];
  logic [W-1:0]  dist_d [0:K-1];
  logic [W-1:0]  type_q [0:K-1];
  logic [W-1:0]  type_d [0:K-1];
  logic [CW-1:0] idx_q, idx_d;
  logic [LW-1:0] cls_q, cls_d;
  logic          err_q, err_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic [LW-1:0] best_cls_q, best_cls_d;
  logic [CW-1:0] best_pos_q, best_pos_d;
  logic [W-1:0]  class_out_q, class_out_d;
  logic [CW-1:0] votes_out_q, votes_out_d;
  logic [W-1:0]  nearest_dist_q, nearest_dist_d;
  logic          type_err_q, type_err_d;
  logic          class_valid_q, class_valid_d;
  logic          overrun_q, overrun_d;

  logic          tally_clr;
  logic          tally_inc;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] rd_first_pos;
  logic [W-1:0]  cur_type;
  logic          label_ok;
  logic          take;
  logic [CW-1:0] new_cnt;
  logic [LW-1:0] new_cls;
  logic [CW-1:0] new_pos;
  logic [W-1:0]  new_dist;
  logic          unused_beyond_k;

  // Entries past K never vote; fold them into a sink so they are visibly ignored.
  always_comb begin
    unused_beyond_k = 1'b0;
    for (int i = K; i < N; i++) begin
      unused_beyond_k = unused_beyond_k ^ (^distance_array_sorted[i]) ^ (^type_array_sorted[i]);
    end
  end

  always_comb begin
    cur_type = '0;
    for (int i = 0; i < K; i++) begin
      if (idx_q == CW'(i)) cur_type = type_q[i];
    end
  end

  // Range check uses the full label; only then do the low bits index the tally.
  assign label_ok = (cur_type < W'(C));

  knn_vote_tally #(
    .K(K),
    .C(C)
  ) u_tally (
    .clk         (clk),
    .rst         (rst),
    .clr         (tally_clr),
    .inc_en      (tally_inc),
    .inc_label   (cur_type[LW-1:0]),
    .inc_idx     (idx_q),
    .rd_cls      (cls_q),
    .rd_cnt      (rd_cnt),
    .rd_first_pos(rd_first_pos)
  );

  // Argmax step: a tie goes to the class whose nearest member ranks earlier.
  // Empty classes never win a tie, so an all-invalid input leaves class 0 / count 0.
  assign take = (rd_cnt > best_cnt_q) ||
                ((rd_cnt == best_cnt_q) && (rd_cnt != '0) && (rd_first_pos < best_pos_q));
  assign new_cnt = take ? rd_cnt       : best_cnt_q;
  assign new_cls = take ? cls_q        : best_cls_q;
  assign new_pos = take ? rd_first_pos : best_pos_q;

  always_comb begin
    new_dist = '0;
    for (int i = 0; i < K; i++) begin
      if (new_pos == CW'(i)) new_dist = dist_q[i];
    end
  end

  always_comb begin
    state_d        = state_q;
    dist_d         = dist_q;
    type_d         = type_q;
    idx_d          = idx_q;
    cls_d          = cls_q;
    err_d          = err_q;
    best_cnt_d     = best_cnt_q;
    best_cls_d     = best_cls_q;
    best_pos_d     = best_pos_q;
    class_out_d    = class_out_q;
    votes_out_d    = votes_out_q;
    nearest_dist_d = nearest_dist_q;
    type_err_d     = type_err_q;
    class_valid_d  = 1'b0;
    overrun_d      = overrun_q | (valid_sort & (state_q != IDLE));
    tally_clr      = 1'b0;
    tally_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_sort) begin
          for (int i = 0; i < K; i++) begin
            dist_d[i] = distance_array_sorted[i];
            type_d[i] = type_array_sorted[i];
          end
          tally_clr = 1'b1;
          err_d     = 1'b0;
          idx_d     = '0;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        if (label_ok) tally_inc = 1'b1;
        else          err_d     = 1'b1;
        if (idx_q == CW'(K - 1)) begin
          state_d    = SELECT;
          cls_d      = '0;
          best_cnt_d = '0;
          best_cls_d = '0;
          best_pos_d = CW'(K);
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      SELECT: begin
        best_cnt_d = new_cnt;
        best_cls_d = new_cls;
        best_pos_d = new_pos;
        // Results are loaded on the last scan step so they are visible in DONE.
        if (cls_q == LW'(C - 1)) begin
          state_d        = DONE;
          class_out_d    = W'(new_cls);
          votes_out_d    = new_cnt;
          nearest_dist_d = (new_cnt == '0) ? '0 : new_dist;
          type_err_d     = err_q;
          class_valid_d  = 1'b1;
        end else begin
          cls_d = cls_q + LW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        type_q[i] <= '0;
      end
      idx_q          <= '0;
      cls_q          <= '0;
      err_q          <= 1'b0;
      best_cnt_q     <= '0;
      best_cls_q     <= '0;
      best_pos_q     <= '0;
      class_out_q    <= '0;
      votes_out_q    <= '0;
      nearest_dist_q <= '0;
      type_err_q     <= 1'b0;
      class_valid_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      dist_q         <= dist_d;
      type_q         <= type_d;
      idx_q          <= idx_d;
      cls_q          <= cls_d;
      err_q          <= err_d;
      best_cnt_q     <= best_cnt_d;
      best_cls_q     <= best_cls_d;
      best_pos_q     <= best_pos_d;
      class_out_q    <= class_out_d;
      votes_out_q    <= votes_out_d;
      nearest_dist_q <= nearest_dist_d;
      type_err_q     <= type_err_d;
      class_valid_q  <= class_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign class_out    = class_out_q;
  assign votes_out    = votes_out_q;
  assign nearest_dist = nearest_dist_q;
  assign type_err     = type_err_q;
  assign class_valid  = class_valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - self-checking bench for knn_vote
module tb_knn_vote;

  localparam int N = 8;
  localparam int W = 8;
  localparam int K = 5;
  localparam int C = 4;

  typedef logic [W-1:0] arr_t [0:N-1];

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_sort;
  arr_t       dist_in;
  arr_t       type_in;
  logic [W-1:0] class_out;
  logic [2:0] votes_out;
  logic [W-1:0] nearest_dist;
  logic       type_err;
  logic       class_valid;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  knn_vote #(.N(N), .W(W), .K(K), .C(C)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .valid_sort           (valid_sort),
    .distance_array_sorted(dist_in),
    .type_array_sorted    (type_in),
    .class_out            (class_out),
    .votes_out            (votes_out),
    .nearest_dist         (nearest_dist),
    .type_err             (type_err),
    .class_valid          (class_valid),
    .busy                 (busy),
    .overrun              (overrun)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int           ob_vcyc;
  int           ob_pulses;
  int           ob_busy;
  logic [W-1:0] ob_cls;
  logic [2:0]   ob_votes;
  logic [W-1:0] ob_nd;
  logic         ob_err;

  arr_t d_lin;
  arr_t d_one;

  // Reference: the winner is the first valid entry (in rank order) whose label
  // occurs strictly more often among the K nearest than any earlier candidate.
  function automatic void model(input arr_t t, input arr_t d, output logic [W-1:0] cls,
                                output int votes, output logic [W-1:0] nd, output logic err);
    int best_j;
    int best_c;
    int c;
    best_j = -1;
    best_c = 0;
    err    = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (t[j] >= C) begin
        err = 1'b1;
      end else begin
        c = 0;
        for (int i = 0; i < K; i++) if (t[i] == t[j]) c++;
        if (c > best_c) begin
          best_c = c;
          best_j = j;
        end
      end
    end
    votes = best_c;
    cls   = (best_j < 0) ? '0 : t[best_j];
    nd    = (best_j < 0) ? '0 : d[best_j];
  endfunction

  // Pulses valid_sort in cycle 0, then observes cycles 1..max_cyc. Optionally injects
  // a second valid_sort (with poison data) or a reset in a chosen cycle.
  task automatic run(input arr_t t, input arr_t d, input int inj_cyc, input int rst_cyc,
                     input int max_cyc);
    ob_vcyc   = 0;
    ob_pulses = 0;
    ob_busy   = 0;
    type_in    = t;
    dist_in    = d;
    valid_sort = 1'b1;
    @(posedge clk); #1;
    valid_sort = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (class_valid) begin
        ob_pulses++;
        if (ob_vcyc == 0) begin
          ob_vcyc  = cyc;
          ob_cls   = class_out;
          ob_votes = votes_out;
          ob_nd    = nearest_dist;
          ob_err   = type_err;
        end
      end
      if (busy) ob_busy++;
      valid_sort = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        for (int i = 0; i < N; i++) begin
          type_in[i] = '0;
          dist_in[i] = 8'hFF;
        end
      end
      rst = (cyc == rst_cyc);
      @(posedge clk); #1;
    end
    valid_sort = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    valid_sort = 1'b0;
    for (int i = 0; i < N; i++) begin
      type_in[i] = '0;
      dist_in[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++; if (class_out !== 8'd0) begin tests_failed++; $display("FAIL reset_class got %0d exp 0", class_out); end
    tests_run++; if (votes_out !== 3'd0) begin tests_failed++; $display("FAIL reset_votes got %0d exp 0", votes_out); end
    tests_run++; if (nearest_dist !== 8'd0) begin tests_failed++; $display("FAIL reset_dist got %0d exp 0", nearest_dist); end
    tests_run++; if ({type_err, class_valid, busy, overrun} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got %b exp 0000", {type_err, class_valid, busy, overrun}); end
  endtask

  task automatic test_majority();
    arr_t t = '{8'd2, 8'd1, 8'd2, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0};
    run(t, d_one, 0, 0, 12);
    tests_run++; if (ob_vcyc !== 10) begin tests_failed++; $display("FAIL maj_cycle got %0d exp 10", ob_vcyc); end
    tests_run++; if (ob_pulses !== 1) begin tests_failed++; $display("FAIL maj_pulses got %0d exp 1", ob_pulses); end
    tests_run++; if (ob_busy !== 10) begin tests_failed++; $display("FAIL maj_busy_cycles got %0d exp 10", ob_busy); end
    tests_run++; if (ob_cls !== 8'd2) begin tests_failed++; $display("FAIL maj_class got %0d exp 2", ob_cls); end
    tests_run++; if (ob_votes !== 3'd3) begin tests_failed++; $display("FAIL maj_votes got %0d exp 3", ob_votes); end
    tests_run++; if (ob_nd !== 8'd1) begin tests_failed++; $display("FAIL maj_dist got %0d exp 1", ob_nd); end
    tests_run++; if (ob_err !== 1'b0) begin tests_failed++; $display("FAIL maj_err got %0d exp 0", ob_err); end
    tests_run++; if ({class_out, votes_out, nearest_dist} !== {8'd2, 3'd3, 8'd1}) begin tests_failed++; $display("FAIL maj_hold got %0d/%0d/%0d exp 2/3/1", class_out, votes_out, nearest_dist); end
  endtask

  task automatic test_tie();
    arr_t t = '{8'd1, 8'd3, 8'd3, 8'd1, 8'd0, 8'd2, 8'd2, 8'd2};
    run(t, d_lin, 0, 0, 10);
    tests_run++; if (ob_vcyc !== 10) begin tests_failed++; $display("FAIL tie_cycle got %0d exp 10", ob_vcyc); end
    tests_run++; if (ob_cls !== 8'd1) begin tests_failed++; $display("FAIL tie_class got %0d exp 1", ob_cls); end
    tests_run++; if (ob_votes !== 3'd2) begin tests_failed++; $display("FAIL tie_votes got %0d exp 2", ob_votes); end
    tests_run++; if (ob_nd !== d_lin[0]) begin tests_failed++; $display("FAIL tie_dist got %0d exp %0d", ob_nd, d_lin[0]); end
  endtask

  task automatic test_invalid();
    arr_t t  = '{8'd7, 8'd0, 8'd9, 8'd0, 8'd5, 8'd1, 8'd1, 8'd1};
    arr_t t2 = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd1, 8'd1, 8'd1};
    run(t, d_lin, 0, 0, 10);
    tests_run++; if (ob_cls !== 8'd0) begin tests_failed++; $display("FAIL inv_class got %0d exp 0", ob_cls); end
    tests_run++; if (ob_votes !== 3'd2) begin tests_failed++; $display("FAIL inv_votes got %0d exp 2", ob_votes); end
    tests_run++; if (ob_nd !== d_lin[1]) begin tests_failed++; $display("FAIL inv_dist got %0d exp %0d", ob_nd, d_lin[1]); end
    tests_run++; if (ob_err !== 1'b1) begin tests_failed++; $display("FAIL inv_err got %0d exp 1", ob_err); end
    run(t2, d_lin, 0, 0, 10);
    tests_run++; if (ob_vcyc !== 10) begin tests_failed++; $display("FAIL allinv_cycle got %0d exp 10", ob_vcyc); end
    tests_run++; if ({ob_cls, ob_votes, ob_nd} !== 19'd0) begin tests_failed++; $display("FAIL allinv_outputs got %0d/%0d/%0d exp 0/0/0", ob_cls, ob_votes, ob_nd); end
    tests_run++; if (ob_err !== 1'b1) begin tests_failed++; $display("FAIL allinv_err got %0d exp 1", ob_err); end
  endtask

  task automatic test_beyond_k();
    arr_t t = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
    run(t, d_lin, 0, 0, 10);
    tests_run++; if (ob_cls !== 8'd1) begin tests_failed++; $display("FAIL beyond_class got %0d exp 1", ob_cls); end
    tests_run++; if (ob_votes !== 3'd3) begin tests_failed++; $display("FAIL beyond_votes got %0d exp 3", ob_votes); end
    tests_run++; if (ob_nd !== d_lin[2]) begin tests_failed++; $display("FAIL beyond_dist got %0d exp %0d", ob_nd, d_lin[2]); end
  endtask

  // Each run ends in cycle 11 of the previous one, so starts are back to back.
  task automatic test_back_to_back();
    arr_t t;
    arr_t d;
    logic [W-1:0] e_cls;
    logic [W-1:0] e_nd;
    logic         e_err;
    int           e_votes;
    for (int n = 0; n < 20; n++) begin
      d[0] = 8'($urandom_range(0, 20));
      for (int i = 1; i < N; i++) d[i] = d[i-1] + 8'($urandom_range(0, 20));
      for (int i = 0; i < N; i++) t[i] = 8'($urandom_range(0, 5));
      model(t, d, e_cls, e_votes, e_nd, e_err);
      run(t, d, 0, 0, 10);
      tests_run++; if (ob_vcyc !== 10) begin tests_failed++; $display("FAIL rnd%0d_cycle got %0d exp 10", n, ob_vcyc); end
      tests_run++; if (ob_cls !== e_cls) begin tests_failed++; $display("FAIL rnd%0d_class got %0d exp %0d", n, ob_cls, e_cls); end
      tests_run++; if (int'(ob_votes) !== e_votes) begin tests_failed++; $display("FAIL rnd%0d_votes got %0d exp %0d", n, ob_votes, e_votes); end
      tests_run++; if (ob_nd !== e_nd) begin tests_failed++; $display("FAIL rnd%0d_dist got %0d exp %0d", n, ob_nd, e_nd); end
      tests_run++; if (ob_err !== e_err) begin tests_failed++; $display("FAIL rnd%0d_err got %0d exp %0d", n, ob_err, e_err); end
    end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun got %0d exp 0", overrun); end
  endtask

  task automatic test_overrun();
    arr_t t  = '{8'd2, 8'd1, 8'd2, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0};
    arr_t t2 = '{8'd1, 8'd3, 8'd3, 8'd1, 8'd0, 8'd2, 8'd2, 8'd2};
    run(t, d_one, 3, 0, 10);
    tests_run++; if (ob_vcyc !== 10) begin tests_failed++; $display("FAIL ovr_cycle got %0d exp 10", ob_vcyc); end
    tests_run++; if ({ob_cls, ob_votes, ob_nd} !== {8'd2, 3'd3, 8'd1}) begin tests_failed++; $display("FAIL ovr_result got %0d/%0d/%0d exp 2/3/1", ob_cls, ob_votes, ob_nd); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %0d exp 1", overrun); end
    run(t2, d_lin, 0, 0, 10);
    tests_run++; if (ob_vcyc !== 10) begin tests_failed++; $display("FAIL ovr_next_cycle got %0d exp 10", ob_vcyc); end
    tests_run++; if ({ob_cls, ob_votes} !== {8'd1, 3'd2}) begin tests_failed++; $display("FAIL ovr_next_result got %0d/%0d exp 1/2", ob_cls, ob_votes); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got %0d exp 1", overrun); end
  endtask

  task automatic test_reset_mid();
    arr_t t = '{8'd2, 8'd1, 8'd2, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0};
    run(t, d_lin, 0, 3, 15);
    tests_run++; if (ob_pulses !== 0) begin tests_failed++; $display("FAIL rstmid_pulses got %0d exp 0", ob_pulses); end
    tests_run++; if (ob_busy !== 3) begin tests_failed++; $display("FAIL rstmid_busy_cycles got %0d exp 3", ob_busy); end
    tests_run++; if ({class_out, votes_out, nearest_dist, type_err} !== 20'd0) begin tests_failed++; $display("FAIL rstmid_outputs got %0d/%0d/%0d/%0d exp 0/0/0/0", class_out, votes_out, nearest_dist, type_err); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rstmid_overrun got %0d exp 0", overrun); end
    run(t, d_one, 0, 0, 10);
    tests_run++; if (ob_vcyc !== 10) begin tests_failed++; $display("FAIL rstmid_fresh_cycle got %0d exp 10", ob_vcyc); end
    tests_run++; if ({ob_cls, ob_votes, ob_nd} !== {8'd2, 3'd3, 8'd1}) begin tests_failed++; $display("FAIL rstmid_fresh_result got %0d/%0d/%0d exp 2/3/1", ob_cls, ob_votes, ob_nd); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      d_lin[i] = 8'(i * 10 + 5);
      d_one[i] = 8'(i + 1);
    end
    test_reset();
    test_majority();
    test_tie();
    test_invalid();
    test_beyond_k();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
